// File: rtl/router_port.sv
// Router-side endpoint of the byte-serial node<->router link: RX reassembly + packet buffer, TX serializer.
// Optional protocol-error checking on the RX side is enabled by defining ROUTER_PORT_ERRCHK_EN.
module router_port #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_rx_put,
    input  logic [7:0]  i_rx_payload,
    output logic        o_rx_free,
    output logic [31:0] o_rx_pkt,
    output logic        o_rx_valid,
    input  logic        i_rx_ready,
    input  logic [31:0] i_tx_pkt,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    input  logic        i_tx_free,
    output logic        o_tx_put,
    output logic [7:0]  o_tx_payload,
    output logic        o_rx_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_S1,
        TX_S2,
        TX_S3
    } txState_t;

    logic [1:0]    r_rxCount;
    logic [23:0]   r_rxShift;
    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [OW-1:0] r_occ;
    logic          r_rxFree;
    logic          r_rxErr;

    txState_t      r_txState;
    logic [31:0]   r_txPkt;
    logic          r_txReady;
    logic          r_txPut;
    logic [7:0]    r_txPayload;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_errPulse;
    logic [1:0]    w_countNext;
    logic [OW-1:0] w_occNext;

    // A byte is taken while a packet is in progress even though rx_free is low (slot is reserved).
    always_comb begin
        w_accept = i_rx_put && (r_rxFree || (r_rxCount != 2'd0));
        w_push   = w_accept && (r_rxCount == 2'd3);
        w_pop    = (r_occ != '0) && i_rx_ready;
`ifdef ROUTER_PORT_ERRCHK_EN
        w_drop     = !i_rx_put && (r_rxCount != 2'd0);
        w_errPulse = w_drop || (i_rx_put && !r_rxFree && (r_rxCount == 2'd0));
`else
        w_drop     = 1'b0;
        w_errPulse = 1'b0;
`endif
        w_countNext = r_rxCount;
        if (w_drop) begin
            w_countNext = 2'd0;
        end else if (w_accept) begin
            w_countNext = r_rxCount + 2'd1;
        end
        w_occNext = r_occ + OW'(w_push) - OW'(w_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rxCount <= 2'd0;
            r_rxShift <= 24'd0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_occ     <= '0;
            r_rxFree  <= 1'b1;
            r_rxErr   <= 1'b0;
        end else begin
            r_rxCount <= w_countNext;
            if (w_accept && !w_push) begin
                r_rxShift <= {r_rxShift[15:0], i_rx_payload};
            end
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
            end
            r_occ    <= w_occNext;
            r_rxFree <= (w_countNext == 2'd0) && (w_occNext != FULL_OCC);
            r_rxErr  <= w_errPulse;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {r_rxShift, i_rx_payload};
        end
    end

    // Once the first byte leaves, the remaining three follow on consecutive cycles without stalling.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_txState   <= TX_IDLE;
            r_txPkt     <= 32'd0;
            r_txReady   <= 1'b1;
            r_txPut     <= 1'b0;
            r_txPayload <= 8'd0;
        end else begin
            case (r_txState)
                TX_IDLE: begin
                    r_txPut <= 1'b0;
                    if (i_tx_valid) begin
                        r_txPkt   <= i_tx_pkt;
                        r_txReady <= 1'b0;
                        r_txState <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (i_tx_free) begin
                        r_txPut     <= 1'b1;
                        r_txPayload <= r_txPkt[31:24];
                        r_txState   <= TX_S1;
                    end else begin
                        r_txPut <= 1'b0;
                    end
                end
                TX_S1: begin
                    r_txPut     <= 1'b1;
                    r_txPayload <= r_txPkt[23:16];
                    r_txState   <= TX_S2;
                end
                TX_S2: begin
                    r_txPut     <= 1'b1;
                    r_txPayload <= r_txPkt[15:8];
                    r_txState   <= TX_S3;
                end
                TX_S3: begin
                    r_txPut     <= 1'b1;
                    r_txPayload <= r_txPkt[7:0];
                    r_txReady   <= 1'b1;
                    r_txState   <= TX_IDLE;
                end
                default: begin
                    r_txPut   <= 1'b0;
                    r_txReady <= 1'b1;
                    r_txState <= TX_IDLE;
                end
            endcase
        end
    end

    assign o_rx_free    = r_rxFree;
    assign o_rx_pkt     = r_mem[r_rdPtr];
    assign o_rx_valid   = (r_occ != '0);
    assign o_rx_err     = r_rxErr;
    assign o_tx_ready   = r_txReady;
    assign o_tx_put     = r_txPut;
    assign o_tx_payload = r_txPayload;

endmodule

// File: tb/tb_router_port.sv
// Directed self-checking bench for router_port (DEPTH=2); error-check scenarios run when ROUTER_PORT_ERRCHK_EN is defined.
module tb_router_port;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rx_put;
    logic [7:0]  rx_payload;
    logic        rx_free;
    logic [31:0] rx_pkt;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_pkt;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_free;
    logic        tx_put;
    logic [7:0]  tx_payload;
    logic        rx_err;

    int total = 0;
    int bad   = 0;

    router_port #(.DEPTH(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_rx_put     (rx_put),
        .i_rx_payload (rx_payload),
        .o_rx_free    (rx_free),
        .o_rx_pkt     (rx_pkt),
        .o_rx_valid   (rx_valid),
        .i_rx_ready   (rx_ready),
        .i_tx_pkt     (tx_pkt),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .i_tx_free    (tx_free),
        .o_tx_put     (tx_put),
        .o_tx_payload (tx_payload),
        .o_rx_err     (rx_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Node-side sender: waits (bounded) for rx_free, then puts four bytes on consecutive cycles.
    task automatic sendRxPkt(input logic [31:0] p);
        for (int w = 0; w < 50 && rx_free !== 1'b1; w++) step();
        if (rx_free !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL send_wait_rx_free got=%b want=1", rx_free);
        end
        for (int b = 0; b < 4; b++) begin
            rx_put = 1'b1;
            rx_payload = p[31 - 8*b -: 8];
            step();
        end
        rx_put = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        total++; if (rx_free !== 1'b1) begin bad++; $display("[TB] FAIL reset_rx_free got=%b want=1", rx_free); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx_ready got=%b want=1", tx_ready); end
        total++; if (tx_put !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_put got=%b want=0", tx_put); end
        total++; if (tx_payload !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_payload got=%h want=00", tx_payload); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_err got=%b want=0", rx_err); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_rx_single();
        logic [7:0] bytes [4];
        bytes[0] = 8'h12; bytes[1] = 8'hAB; bytes[2] = 8'hCD; bytes[3] = 8'hEF;
        total++; if (rx_free !== 1'b1) begin bad++; $display("[TB] FAIL single_free_before got=%b want=1", rx_free); end
        for (int b = 0; b < 3; b++) begin
            rx_put = 1'b1; rx_payload = bytes[b];
            step();
            total++; if (rx_free !== 1'b0) begin bad++; $display("[TB] FAIL single_free_low_%0d got=%b want=0", b, rx_free); end
            total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_early_%0d got=%b want=0", b, rx_valid); end
        end
        rx_payload = bytes[3];
        step();
        rx_put = 1'b0;
        total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", rx_valid); end
        total++; if (rx_pkt !== 32'h12ABCDEF) begin bad++; $display("[TB] FAIL single_pkt got=%h want=12abcdef", rx_pkt); end
        total++; if (rx_free !== 1'b1) begin bad++; $display("[TB] FAIL single_free_after got=%b want=1", rx_free); end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_pop_empty got=%b want=0", rx_valid); end
    endtask

    task automatic test_rx_full();
        rx_ready = 1'b0;
        sendRxPkt(32'h11223344);
        sendRxPkt(32'h55667788);
        total++; if (rx_free !== 1'b0) begin bad++; $display("[TB] FAIL full_free got=%b want=0", rx_free); end
        total++; if (rx_pkt !== 32'h11223344) begin bad++; $display("[TB] FAIL full_head_a got=%h want=11223344", rx_pkt); end
        rx_put = 1'b1; rx_payload = 8'h99;
        step();
        rx_put = 1'b0;
        step(); step();
        total++; if (rx_free !== 1'b0) begin bad++; $display("[TB] FAIL full_free_held got=%b want=0", rx_free); end
        total++; if (rx_pkt !== 32'h11223344) begin bad++; $display("[TB] FAIL full_ignored_put got=%h want=11223344", rx_pkt); end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        total++; if (rx_free !== 1'b1) begin bad++; $display("[TB] FAIL full_free_after_pop got=%b want=1", rx_free); end
        total++; if (rx_pkt !== 32'h55667788) begin bad++; $display("[TB] FAIL full_head_b got=%h want=55667788", rx_pkt); end
        sendRxPkt(32'h9900AABB);
        total++; if (rx_pkt !== 32'h55667788) begin bad++; $display("[TB] FAIL full_head_b2 got=%h want=55667788", rx_pkt); end
        rx_ready = 1'b1;
        step();
        total++; if (rx_pkt !== 32'h9900AABB) begin bad++; $display("[TB] FAIL full_head_c got=%h want=9900aabb", rx_pkt); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_valid_c got=%b want=1", rx_valid); end
        step();
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_drained got=%b want=0", rx_valid); end
    endtask

`ifndef ROUTER_PORT_ERRCHK_EN
    task automatic test_gap();
        rx_put = 1'b1; rx_payload = 8'h7E; step();
        rx_payload = 8'h01; step();
        rx_put = 1'b0; step(); step();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL gap_valid_early got=%b want=0", rx_valid); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL gap_err got=%b want=0", rx_err); end
        rx_put = 1'b1; rx_payload = 8'h02; step();
        rx_payload = 8'h03; step();
        rx_put = 1'b0;
        total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap_valid got=%b want=1", rx_valid); end
        total++; if (rx_pkt !== 32'h7E010203) begin bad++; $display("[TB] FAIL gap_pkt got=%h want=7e010203", rx_pkt); end
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
    endtask
`else
    task automatic test_errchk();
        rx_put = 1'b1; rx_payload = 8'h5A; step();
        rx_payload = 8'h5B; step();
        rx_put = 1'b0; step();
        total++; if (rx_err !== 1'b1) begin bad++; $display("[TB] FAIL err_pulse got=%b want=1", rx_err); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL err_no_valid got=%b want=0", rx_valid); end
        total++; if (rx_free !== 1'b1) begin bad++; $display("[TB] FAIL err_free got=%b want=1", rx_free); end
        step();
        total++; if (rx_err !== 1'b0) begin bad++; $display("[TB] FAIL err_one_cycle got=%b want=0", rx_err); end
        sendRxPkt(32'h5C112233);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL err_next_valid got=%b want=1", rx_valid); end
        total++; if (rx_pkt !== 32'h5C112233) begin bad++; $display("[TB] FAIL err_next_pkt got=%h want=5c112233", rx_pkt); end
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
    endtask
`endif

    task automatic test_tx_basic();
        logic [7:0] bytes [4];
        bytes[0] = 8'h35; bytes[1] = 8'h0A; bytes[2] = 8'h0B; bytes[3] = 8'h0C;
        tx_free = 1'b1; tx_valid = 1'b1; tx_pkt = 32'h350A0B0C;
        total++; if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL tx_ready_idle got=%b want=1", tx_ready); end
        step();
        tx_valid = 1'b0;
        total++; if (tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL tx_ready_busy got=%b want=0", tx_ready); end
        total++; if (tx_put !== 1'b0) begin bad++; $display("[TB] FAIL tx_put_accept got=%b want=0", tx_put); end
        for (int b = 0; b < 4; b++) begin
            step();
            total++; if (tx_put !== 1'b1) begin bad++; $display("[TB] FAIL tx_put_%0d got=%b want=1", b, tx_put); end
            total++; if (tx_payload !== bytes[b]) begin bad++; $display("[TB] FAIL tx_byte_%0d got=%h want=%h", b, tx_payload, bytes[b]); end
        end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL tx_ready_done got=%b want=1", tx_ready); end
        step();
        total++; if (tx_put !== 1'b0) begin bad++; $display("[TB] FAIL tx_put_end got=%b want=0", tx_put); end
    endtask

    task automatic test_tx_stall();
        logic [7:0] bytes [4];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; bytes[3] = 8'hD4;
        tx_free = 1'b0; tx_valid = 1'b1; tx_pkt = 32'hA1B2C3D4;
        step();
        tx_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            total++; if (tx_put !== 1'b0) begin bad++; $display("[TB] FAIL stall_put_%0d got=%b want=0", c, tx_put); end
        end
        tx_free = 1'b1;
        for (int b = 0; b < 4; b++) begin
            step();
            tx_free = 1'b0;
            total++; if (tx_put !== 1'b1) begin bad++; $display("[TB] FAIL stall_put_on_%0d got=%b want=1", b, tx_put); end
            total++; if (tx_payload !== bytes[b]) begin bad++; $display("[TB] FAIL stall_byte_%0d got=%h want=%h", b, tx_payload, bytes[b]); end
        end
        step();
        total++; if (tx_put !== 1'b0) begin bad++; $display("[TB] FAIL stall_put_end got=%b want=0", tx_put); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rxPk [4];
        logic [31:0] txPk [4];
        logic [31:0] rxGot [8];
        logic [31:0] txGot [8];
        logic [31:0] txShift;
        int rs, bi, ts, nRx, nTx, tb;
        rxPk[0] = 32'hC1000001; rxPk[1] = 32'hC2F0F0F0; rxPk[2] = 32'hC3123456; rxPk[3] = 32'hC4FFFFFF;
        txPk[0] = 32'h4700AA55; txPk[1] = 32'h48010203; txPk[2] = 32'h49DEADBE; txPk[3] = 32'h4A000000;
        rs = 0; bi = 0; ts = 0; nRx = 0; nTx = 0; tb = 0; txShift = 32'd0;
        rx_ready = 1'b1; tx_free = 1'b1;
        for (int c = 0; c < 100 && (nRx < 4 || nTx < 4); c++) begin
            if (rx_valid === 1'b1 && nRx < 8) begin rxGot[nRx] = rx_pkt; nRx++; end
            if (tx_put === 1'b1) begin
                txShift = {txShift[23:0], tx_payload};
                tb++;
                if (tb == 4) begin
                    if (nTx < 8) txGot[nTx] = txShift;
                    nTx++; tb = 0;
                end
            end
            if (bi != 0 || (rx_free === 1'b1 && rs < 4)) begin
                rx_put = 1'b1;
                rx_payload = rxPk[rs][31 - 8*bi -: 8];
                bi++;
                if (bi == 4) begin bi = 0; rs++; end
            end else begin
                rx_put = 1'b0;
            end
            if (tx_ready === 1'b1 && ts < 4) begin
                tx_valid = 1'b1; tx_pkt = txPk[ts]; ts++;
            end else begin
                tx_valid = 1'b0;
            end
            step();
        end
        rx_put = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
        total++; if (nRx != 4) begin bad++; $display("[TB] FAIL b2b_rx_count got=%0d want=4", nRx); end
        total++; if (nTx != 4) begin bad++; $display("[TB] FAIL b2b_tx_count got=%0d want=4", nTx); end
        for (int i = 0; i < 4; i++) begin
            if (i < nRx) begin
                total++; if (rxGot[i] !== rxPk[i]) begin bad++; $display("[TB] FAIL b2b_rx_pkt_%0d got=%h want=%h", i, rxGot[i], rxPk[i]); end
            end
            if (i < nTx) begin
                total++; if (txGot[i] !== txPk[i]) begin bad++; $display("[TB] FAIL b2b_tx_pkt_%0d got=%h want=%h", i, txGot[i], txPk[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        rx_ready = 1'b0;
        sendRxPkt(32'h0F0E0D0C);
        tx_free = 1'b1; tx_valid = 1'b1; tx_pkt = 32'h99887766;
        rx_put = 1'b1; rx_payload = 8'hAA;
        step();
        tx_valid = 1'b0; rx_payload = 8'hBB;
        step();
        rx_put = 1'b0;
        total++; if (tx_put !== 1'b1) begin bad++; $display("[TB] FAIL mid_tx_started got=%b want=1", tx_put); end
        reset_n = 1'b0;
        step();
        total++; if (tx_put !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_tx_put got=%b want=0", tx_put); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_tx_ready got=%b want=1", tx_ready); end
        total++; if (tx_payload !== 8'h00) begin bad++; $display("[TB] FAIL mid_reset_payload got=%h want=00", tx_payload); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (rx_free !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_rx_free got=%b want=1", rx_free); end
        reset_n = 1'b1;
        step();
        sendRxPkt(32'h12345678);
        total++; if (rx_pkt !== 32'h12345678) begin bad++; $display("[TB] FAIL mid_after_pkt got=%h want=12345678", rx_pkt); end
        total++; if (tx_put !== 1'b0) begin bad++; $display("[TB] FAIL mid_tx_discarded got=%b want=0", tx_put); end
    endtask

    initial begin
        reset_n = 1'b0; rx_put = 1'b0; rx_payload = 8'h00; rx_ready = 1'b0;
        tx_pkt = 32'd0; tx_valid = 1'b0; tx_free = 1'b0;
        test_reset();
        test_rx_single();
        test_rx_full();
`ifndef ROUTER_PORT_ERRCHK_EN
        test_gap();
`else
        test_errchk();
`endif
        test_tx_basic();
        test_tx_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
